// File: rtl/conv2_relu_pool_pkg.sv
// Shared types and default geometry for the conv2 ReLU + 2x2 max-pool stage.
package conv2_pool_pkg;

  localparam int DFLT_WIDTH      = 13;
  localparam int DFLT_HEIGHT     = 17;
  localparam int DFLT_FILTER_NUM = 64;
  // Floor division: an odd trailing column/row has no partner and is dropped.
  localparam int DFLT_OUT_W      = DFLT_WIDTH / 2;
  localparam int DFLT_OUT_H      = DFLT_HEIGHT / 2;

  localparam logic [31:0] ZERO_F32 = 32'h0000_0000;

  typedef logic [31:0] f32_t;

endpackage

// File: rtl/conv2_relu_pool_if.sv
// Pixel-stream bundle between the conv2 accumulator, this stage and the next layer.
interface conv2_relu_pool_if
  import conv2_pool_pkg::*;
#(
  parameter int FILTER_NUM = DFLT_FILTER_NUM
);

  logic valid_in;
  f32_t data_in  [0:FILTER_NUM-1];
  logic valid_out;
  f32_t data_out [0:FILTER_NUM-1];
  logic frame_done;

  // Upstream/downstream side: drives input pixels, observes pooled pixels.
  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  frame_done
  );

  // Pooling stage side.
  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output frame_done
  );

endinterface

// File: rtl/conv2_relu_pool_relu_max2.sv
// Single-lane max(relu(a), relu(b)). With both operands non-negative after
// ReLU, the float ordering equals the unsigned ordering of the bit patterns.
module relu_max2
  import conv2_pool_pkg::*;
(
  input  f32_t a_i,
  input  f32_t b_i,
  output f32_t y_o
);

  // Sign bit set covers negatives, -0.0 and 0x80000000: all clamp to +0.0.
  function automatic f32_t relu(input f32_t x);
    return x[31] ? ZERO_F32 : x;
  endfunction

  f32_t ra;
  f32_t rb;

  // Clamp both operands, then keep the larger bit pattern.
  always_comb begin
    ra  = relu(a_i);
    rb  = relu(b_i);
    y_o = (ra > rb) ? ra : rb;
  end

endmodule

// File: rtl/conv2_relu_pool.sv
// ReLU + 2x2 stride-2 max pooling on the raster-ordered conv2 output stream.
// Even columns park their pixel in a hold register, odd columns of even rows
// fold the horizontal pair into a line buffer, and odd columns of odd rows
// merge with the line buffer to produce one pooled pixel a cycle later.
module conv2_relu_pool
  import conv2_pool_pkg::*;
#(
  parameter int WIDTH      = DFLT_WIDTH,
  parameter int HEIGHT     = DFLT_HEIGHT,
  parameter int FILTER_NUM = DFLT_FILTER_NUM
)(
  input  logic               clk,
  input  logic               rst,
  conv2_relu_pool_if.slave   bus
);

  localparam int OUT_W = WIDTH / 2;
  localparam int OUT_H = HEIGHT / 2;
  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW    = (OUT_W  > 1) ? $clog2(OUT_W)  : 1;

  localparam logic [CW-1:0] W_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] H_LAST   = RW'(HEIGHT - 1);
  // One extra bit so 2*OUT_W / 2*OUT_H never truncate when WIDTH/HEIGHT are powers of two.
  localparam logic [CW:0]   W_LIM    = (CW+1)'(2 * OUT_W);
  localparam logic [RW:0]   H_LIM    = (RW+1)'(2 * OUT_H);
  localparam logic [CW-1:0] W_POOL_L = CW'(2 * OUT_W - 1);
  localparam logic [RW-1:0] H_POOL_L = RW'(2 * OUT_H - 1);

  function automatic f32_t relu(input f32_t x);
    return x[31] ? ZERO_F32 : x;
  endfunction

  logic [CW-1:0] w_q, w_d;
  logic [RW-1:0] h_q, h_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_done_q, frame_done_d;

  f32_t hold_q     [0:FILTER_NUM-1];
  f32_t linebuf_q  [0:OUT_W-1][0:FILTER_NUM-1];
  f32_t data_out_q [0:FILTER_NUM-1];

  f32_t relu_in    [0:FILTER_NUM-1];
  f32_t pair_max   [0:FILTER_NUM-1];
  f32_t pool_max   [0:FILTER_NUM-1];

  logic          beat;
  logic          in_win;
  logic          hold_we;
  logic          lbuf_we;
  logic          fire;
  logic          last_px;
  logic [BW-1:0] col;

  // Decode what the current beat does; reset drops a coincident beat.
  always_comb begin
    beat    = bus.valid_in && !rst;
    in_win  = ({1'b0, w_q} < W_LIM) && ({1'b0, h_q} < H_LIM);
    hold_we = beat && in_win && !w_q[0];
    lbuf_we = beat && in_win &&  w_q[0] && !h_q[0];
    fire    = beat && in_win &&  w_q[0] &&  h_q[0];
    last_px = (w_q == W_POOL_L) && (h_q == H_POOL_L);
    col     = in_win ? BW'(w_q >> 1) : '0;
  end

  // Raster position: w wraps at the row end, h wraps at the frame end.
  always_comb begin
    w_d = w_q;
    h_d = h_q;
    if (bus.valid_in) begin
      if (w_q == W_LAST) begin
        w_d = '0;
        h_d = (h_q == H_LAST) ? '0 : h_q + RW'(1);
      end else begin
        w_d = w_q + CW'(1);
      end
    end
  end

  // Output strobes follow the pooled-pixel trigger by one cycle.
  always_comb begin
    valid_out_d  = fire;
    frame_done_d = fire && last_px;
  end

  for (genvar k = 0; k < FILTER_NUM; k++) begin : g_lane
    assign relu_in[k] = relu(bus.data_in[k]);

    relu_max2 u_pair (
      .a_i (hold_q[k]),
      .b_i (bus.data_in[k]),
      .y_o (pair_max[k])
    );

    relu_max2 u_row (
      .a_i (linebuf_q[col][k]),
      .b_i (pair_max[k]),
      .y_o (pool_max[k])
    );

    assign bus.data_out[k] = data_out_q[k];
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;

  // Position counters; only beats advance them.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      h_q <= '0;
    end else begin
      w_q <= w_d;
      h_q <= h_d;
    end
  end

  // Hold register: ReLU'd left pixel of the current horizontal pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FILTER_NUM; k++) hold_q[k] <= ZERO_F32;
    end else if (hold_we) begin
      for (int k = 0; k < FILTER_NUM; k++) hold_q[k] <= relu_in[k];
    end
  end

  // Line buffer: even-row pair maxima, always rewritten before the odd row reads them.
  always_ff @(posedge clk) begin
    if (lbuf_we) begin
      for (int k = 0; k < FILTER_NUM; k++) linebuf_q[col][k] <= pair_max[k];
    end
  end

  // Pooled output register; data holds between valid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < FILTER_NUM; k++) data_out_q[k] <= ZERO_F32;
    end else begin
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      if (fire) begin
        for (int k = 0; k < FILTER_NUM; k++) data_out_q[k] <= pool_max[k];
      end
    end
  end

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed bench for conv2_relu_pool with a queue-based scoreboard.
module tb_conv2_relu_pool;
  import conv2_pool_pkg::*;

  localparam int FN = DFLT_FILTER_NUM;
  localparam int W  = DFLT_WIDTH;
  localparam int H  = DFLT_HEIGHT;
  localparam int OW = W / 2;
  localparam int OH = H / 2;

  typedef logic [FN-1:0][31:0] vec_t;
  typedef struct {
    vec_t v;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2_relu_pool_if #(.FILTER_NUM(FN)) bus ();

  conv2_relu_pool #(.WIDTH(W), .HEIGHT(H), .FILTER_NUM(FN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   out_cnt = 0;
  vec_t outs [0:OW*OH-1];
  vec_t last_out;
  logic have_last = 1'b0;

  // Exact conversion of a small non-negative integer to float32.
  function automatic logic [31:0] int2f(input int x);
    int          msb;
    logic [31:0] t;
    logic [7:0]  e;
    if (x == 0) return 32'h0;
    msb = 0;
    for (int b = 0; b < 31; b++) if (((x >> b) & 1) == 1) msb = b;
    t = 32'(x) << (23 - msb);
    e = 8'(127 + msb);
    return {1'b0, e, t[22:0]};
  endfunction

  function automatic logic [31:0] pix(input int mode, input int w, input int h, input int k);
    if (mode == 1) return int2f(100 * h + w + k);
    if (mode == 2) return 32'h3F80_0000;
    // mode 0: sparse frame with hand-picked windows, zero elsewhere
    if (w < 2 && h < 2) begin
      if (k != 0) return 32'h0;
      if (w == 0 && h == 0) return 32'h4040_0000;
      if (w == 1 && h == 0) return 32'h3F80_0000;
      if (w == 0 && h == 1) return 32'hC0A0_0000;
      return 32'h4000_0000;
    end
    if (w >= 2 && w < 4 && h < 2)
      return (k % 2 == 1) ? 32'h8000_0000 : (32'hC000_0000 | 32'(k << 4) | 32'(w) | 32'(h << 8));
    if (w >= 4 && w < 6 && h < 2) begin
      if (w == 4 && h == 1 && k == 1) return 32'h7F80_0000;
      if (w == 5 && h == 0 && k == 2) return 32'h7FC0_0000;
      if (w == 4 && h == 0 && k == 3) return 32'h0000_0001;
      return 32'hBF80_0000;
    end
    return 32'h0;
  endfunction

  // Reference: max over the whole 2x2 window of clamped patterns.
  function automatic vec_t exp_pool(input int mode, input int i, input int j);
    vec_t        v;
    logic [31:0] m, p;
    for (int k = 0; k < FN; k++) begin
      m = 32'h0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          p = pix(mode, 2 * i + dx, 2 * j + dy, k);
          if (p[31]) p = 32'h0;
          if (p > m) m = p;
        end
      v[k] = m;
    end
    return v;
  endfunction

  function automatic vec_t cur_out();
    vec_t v;
    for (int k = 0; k < FN; k++) v[k] = bus.data_out[k];
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < FN; k++) v[k] = $urandom;
    return v;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
    int bad;
    bad = -1;
    for (int k = 0; k < FN; k++) if (obs[k] !== exp[k] && bad < 0) bad = k;
    if (bad < 0) bad = 0;
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, bad, obs[bad], exp[bad]);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive a beat (or idle), then check the registered outputs.
  task automatic step(input logic vld, input vec_t din, input logic trig, input exp_t e,
                      input string tag);
    exp_t got;
    vec_t o;
    if (trig) sb.push_back(e);
    bus.valid_in = vld;
    for (int k = 0; k < FN; k++) bus.data_in[k] = din[k];
    @(posedge clk);
    #1;
    chk_bit({tag, " valid_out"}, bus.valid_out, trig);
    chk_bit({tag, " frame_done"}, bus.frame_done, trig && e.last);
    o = cur_out();
    if (bus.valid_out === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL %s unexpected output: observed 1 pending expected 0 pending", tag);
      end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk_vec({tag, " data_out"}, o, got.v);
      end
      if (out_cnt < OW * OH) outs[out_cnt] = o;
      out_cnt++;
      last_out  = o;
      have_last = 1'b1;
    end else if (have_last) begin
      chk_vec({tag, " hold"}, o, last_out);
    end
  endtask

  task automatic send_frame(input int mode, input int max_gap, input int nbeats,
                            input string tag);
    int   n;
    exp_t e;
    exp_t idle;
    vec_t din;
    logic trig;
    n       = 0;
    out_cnt = 0;
    idle.v    = '0;
    idle.last = 1'b0;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++) begin
        if (n >= nbeats) return;
        repeat ($urandom_range(0, max_gap)) step(1'b0, rand_vec(), 1'b0, idle, tag);
        for (int k = 0; k < FN; k++) din[k] = pix(mode, w, h, k);
        trig = (w % 2 == 1) && (h % 2 == 1) && (w < 2 * OW) && (h < 2 * OH);
        e.v    = trig ? exp_pool(mode, w / 2, h / 2) : '0;
        e.last = (w == 2 * OW - 1) && (h == 2 * OH - 1);
        step(1'b1, din, trig, e, tag);
        n++;
      end
  endtask

  initial begin
    exp_t idle;
    idle.v    = '0;
    idle.last = 1'b0;
    bus.valid_in = 1'b0;
    for (int k = 0; k < FN; k++) bus.data_in[k] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset valid_out", bus.valid_out, 1'b0);
    chk_bit("reset frame_done", bus.frame_done, 1'b0);
    chk_vec("reset data_out", cur_out(), '0);
    rst       = 1'b0;
    last_out  = '0;
    have_last = 1'b1;

    // Sparse frame: hand-picked windows, ReLU corners
    send_frame(0, 0, W * H, "s1");
    chk_int("s1 count", out_cnt, OW * OH);
    chk_word("s1 pool00 lane0", outs[0][0], 32'h4040_0000);
    chk_vec("s1 pool10 negatives", outs[1], '0);
    chk_word("s1 pool20 lane0", outs[2][0], 32'h0);
    chk_word("s1 pool20 +inf", outs[2][1], 32'h7F80_0000);
    chk_word("s1 pool20 nan", outs[2][2], 32'h7FC0_0000);
    chk_word("s1 pool20 denorm", outs[2][3], 32'h0000_0001);

    // Ramp frame, continuous valid
    send_frame(1, 0, W * H, "s3");
    chk_int("s3 count", out_cnt, OW * OH);
    chk_word("s3 first lane0", outs[0][0], int2f(101));
    chk_word("s3 last lane5", outs[OW*OH-1][5], int2f(100 * (2 * OH - 1) + 2 * OW - 1 + 5));

    // Ramp frame with random gaps
    send_frame(1, 3, W * H, "s4");
    chk_int("s4 count", out_cnt, OW * OH);
    chk_word("s4 out7 lane9", outs[7][9], int2f(100 * 3 + 3 + 9));

    // Back-to-back frames, second all 1.0
    send_frame(1, 0, W * H, "s5a");
    send_frame(2, 0, W * H, "s5b");
    chk_int("s5 count", out_cnt, OW * OH);
    chk_word("s5 out0 lane63", outs[0][FN-1], 32'h3F80_0000);
    chk_word("s5 out47 lane0", outs[OW*OH-1][0], 32'h3F80_0000);

    // Mid-frame reset with a coincident beat, then a full frame
    send_frame(1, 0, 100, "s6a");
    rst          = 1'b1;
    bus.valid_in = 1'b1;
    for (int k = 0; k < FN; k++) bus.data_in[k] = $urandom;
    @(posedge clk);
    #1;
    chk_bit("s6 rst valid_out", bus.valid_out, 1'b0);
    chk_bit("s6 rst frame_done", bus.frame_done, 1'b0);
    chk_vec("s6 rst data_out", cur_out(), '0);
    rst      = 1'b0;
    last_out = '0;
    chk_int("s6 pending after rst", sb.size(), 0);
    sb.delete();
    send_frame(1, 0, W * H, "s6b");
    chk_int("s6 count", out_cnt, OW * OH);
    chk_word("s6 first lane0", outs[0][0], int2f(101));

    // Trailing idle cycles: output must hold
    repeat (4) step(1'b0, rand_vec(), 1'b0, idle, "tail");
    chk_int("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
